// File: rtl/result_trace_buffer_if.sv
// rtl/result_trace_buffer_if.sv - capture, drain and status signals of the result trace buffer
interface result_trace_buffer_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] result_in;
  logic             capture_en;
  logic             change_only;
  logic             out_ready;
  logic             ovf_clr;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [15:0]      drop_cnt;

  // Master drives samples and consumes the trace; slave is the buffer itself.
  modport master (
    output result_in, capture_en, change_only, out_ready, ovf_clr,
    input  out_valid, out_data, count, full, empty, overflow, drop_cnt
  );

  modport slave (
    input  result_in, capture_en, change_only, out_ready, ovf_clr,
    output out_valid, out_data, count, full, empty, overflow, drop_cnt
  );
endinterface

// File: rtl/result_trace_buffer.sv
// rtl/result_trace_buffer.sv - first-word-fall-through trace FIFO of processor results with change filter
module result_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  result_trace_buffer_if.slave bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             last_valid_q, last_valid_d;
  logic [WIDTH-1:0] last_value_q, last_value_d;

  logic empty;
  logic full;
  logic qualify;
  logic pop;
  logic push;
  logic drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // A sample counts when capture is on and, in change-only mode, it differs from the
  // previous qualifying sample (the very first sample after reset always counts).
  assign qualify = bus.capture_en &&
                   (!bus.change_only || !last_valid_q || (bus.result_in != last_value_q));
  assign pop     = !empty && bus.out_ready;
  // A full buffer still accepts a sample when the head leaves on the same edge.
  assign push    = qualify && (!full || pop);
  assign drop    = qualify && full && !pop;

  // Next-state for pointers, occupancy, overflow bookkeeping and the change filter.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    drop_cnt_d   = drop_cnt_q;
    last_valid_d = last_valid_q;
    last_value_d = last_value_q;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // The filter tracks every qualifying sample, including ones that get dropped.
    if (qualify) begin
      last_valid_d = 1'b1;
      last_value_d = bus.result_in;
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    // Clear beats a drop in the same cycle.
    if (bus.ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = 16'd0;
    end
  end

  // Control state registers; reset discards every entry at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 16'd0;
      last_valid_q <= 1'b0;
      last_value_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      last_valid_q <= last_valid_d;
      last_value_q <= last_value_d;
    end
  end

  // Entry storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.result_in;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;
  assign bus.drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_result_trace_buffer.sv
// tb/tb_result_trace_buffer.sv - self-checking bench for result_trace_buffer
module tb_result_trace_buffer;
  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  result_trace_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  result_trace_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Scoreboard and reference state.
  logic [31:0] sb_q[$];
  logic        m_last_valid;
  logic [31:0] m_last_value;
  logic        m_ovf;
  logic [15:0] m_drop;

  typedef struct {
    logic        cap;
    logic        chg;
    logic [31:0] din;
    logic        rdy;
    logic        clr;
    int          exp_cnt;
    logic        exp_ovf;
    int          exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic cap, input logic chg, input logic [31:0] din,
                              input logic rdy, input logic clr, input int exp_cnt,
                              input logic exp_ovf, input int exp_drop);
    vec_t v;
    v.cap = cap; v.chg = chg; v.din = din; v.rdy = rdy; v.clr = clr;
    v.exp_cnt = exp_cnt; v.exp_ovf = exp_ovf; v.exp_drop = exp_drop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cap, input logic chg, input logic [31:0] din,
                       input logic rdy, input logic clr);
    bus.capture_en  = cap;
    bus.change_only = chg;
    bus.result_in   = din;
    bus.out_ready   = rdy;
    bus.ovf_clr     = clr;
  endtask

  task automatic model_clear();
    sb_q.delete();
    m_last_valid = 1'b0;
    m_last_value = '0;
    m_ovf        = 1'b0;
    m_drop       = 16'd0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] exp_data;
    exp_data = '0;
    if (sb_q.size() != 0) exp_data = sb_q[0];
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(sb_q.size() != 0));
    chk({tag, " empty"},     32'(bus.empty),     32'(sb_q.size() == 0));
    chk({tag, " full"},      32'(bus.full),      32'(sb_q.size() == DEPTH));
    chk({tag, " count"},     32'(bus.count),     32'(sb_q.size()));
    chk({tag, " overflow"},  32'(bus.overflow),  32'(m_ovf));
    chk({tag, " drop_cnt"},  32'(bus.drop_cnt),  32'(m_drop));
    chk({tag, " out_data"},  bus.out_data,       exp_data);
  endtask

  // Checks current outputs, advances the reference model by one edge, then clocks.
  task automatic tick(input string tag, input bit do_chk);
    bit          qual;
    bit          pop;
    bit          full_m;
    logic [31:0] exp;
    if (do_chk) check_state(tag);
    full_m = (sb_q.size() == DEPTH);
    qual   = bus.capture_en &&
             (!bus.change_only || !m_last_valid || (bus.result_in != m_last_value));
    pop    = (sb_q.size() != 0) && bus.out_ready;
    if (pop) begin
      exp = sb_q.pop_front();
      chk({tag, " pop data"}, bus.out_data, exp);
    end
    if (qual) begin
      m_last_valid = 1'b1;
      m_last_value = bus.result_in;
      if (!full_m || pop) begin
        sb_q.push_back(bus.result_in);
      end else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
      end
    end
    if (bus.ovf_clr) begin
      m_ovf  = 1'b0;
      m_drop = 16'd0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    reset = 1'b1;
    check_state("reset");
  endtask

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      drive(vecs[i].cap, vecs[i].chg, vecs[i].din, vecs[i].rdy, vecs[i].clr);
      tick($sformatf("%s[%0d]", tag, i), 1'b1);
      chk($sformatf("%s[%0d] tbl count", tag, i), 32'(bus.count), 32'(vecs[i].exp_cnt));
      chk($sformatf("%s[%0d] tbl overflow", tag, i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      chk($sformatf("%s[%0d] tbl drop_cnt", tag, i), 32'(bus.drop_cnt), 32'(vecs[i].exp_drop));
    end
    vecs.delete();
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick(tag, 1'b1);
    end
  endtask

  initial begin
    int vals[6];
    int cnts[6];
    vals = '{5, 5, 5, 7, 7, 5};
    cnts = '{1, 1, 1, 2, 2, 3};

    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    do_reset();

    // Fill with 10 distinct values, drain, idle pop, then clear.
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 0, 32'(i + 1), 0, 0, (i < 8) ? i + 1 : 8, i >= 8, (i >= 8) ? i - 7 : 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(0, 0, '0, 1, 0, 7 - i, 1, 2));
    vecs.push_back(mk(0, 0, '0, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, '0, 0, 1, 0, 0, 0));
    run_vecs("fill");
    check_state("fill end");

    // Change-only filter.
    do_reset();
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1, 1, 32'(vals[i]), 0, 0, cnts[i], 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, '0, 1, 0, 2 - i, 0, 0));
    run_vecs("filter");

    // Full with concurrent pop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 32'(200 + i), 1'b0, 1'b0);
      tick("cpop fill", 1'b1);
    end
    chk("cpop full", 32'(bus.full), 32'd1);
    drive(1'b1, 1'b0, 32'd9, 1'b1, 1'b0);
    tick("cpop push", 1'b1);
    chk("cpop count", 32'(bus.count), 32'd8);
    chk("cpop overflow", 32'(bus.overflow), 32'd0);
    chk("cpop head", bus.out_data, 32'd201);
    drain("cpop drain", 8);
    chk("cpop empty", 32'(bus.empty), 32'd1);

    // Wrap-around with single push/pop pairs.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'(100 + i), 1'b1, 1'b0);
      tick("wrap push", 1'b1);
      chk($sformatf("wrap[%0d] valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("wrap[%0d] data", i), bus.out_data, 32'(100 + i));
      chk($sformatf("wrap[%0d] count", i), 32'(bus.count), 32'd1);
      drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
      tick("wrap pop", 1'b1);
    end
    chk("wrap final count", 32'(bus.count), 32'd0);

    // Head holds while stalled.
    do_reset();
    drive(1'b1, 1'b0, 32'hAAAA, 1'b0, 1'b0);
    tick("hold push", 1'b1);
    drive(1'b1, 1'b0, 32'hBBBB, 1'b0, 1'b0);
    tick("hold push", 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick("hold idle", 1'b1);
      chk("hold data", bus.out_data, 32'hAAAA);
    end
    drain("hold drain", 2);

    // Asynchronous reset mid-operation, then immediate reuse.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'(300 + i), 1'b0, 1'b0);
      tick("mid fill", 1'b1);
    end
    chk("mid count", 32'(bus.count), 32'd5);
    reset = 1'b0;
    #1;
    chk("mid rst empty", 32'(bus.empty), 32'd1);
    chk("mid rst valid", 32'(bus.out_valid), 32'd0);
    chk("mid rst count", 32'(bus.count), 32'd0);
    chk("mid rst data", bus.out_data, 32'd0);
    model_clear();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h55, 1'b0, 1'b0);
    tick("mid reuse", 1'b1);
    chk("mid reuse valid", 32'(bus.out_valid), 32'd1);
    chk("mid reuse data", bus.out_data, 32'h55);
    drain("mid drain", 1);

    // Drop counter saturation, then clear alongside a drop.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 32'(400 + i), 1'b0, 1'b0);
      tick("sat fill", 1'b1);
    end
    for (int n = 0; n < 70000; n++) begin
      drive(1'b1, 1'b0, 32'(n), 1'b0, 1'b0);
      tick("sat", 1'b0);
    end
    chk("sat drop_cnt", 32'(bus.drop_cnt), 32'h0000FFFF);
    chk("sat overflow", 32'(bus.overflow), 32'd1);
    drive(1'b1, 1'b0, 32'd7, 1'b0, 1'b1);
    tick("sat clr", 1'b1);
    chk("clr drop_cnt", 32'(bus.drop_cnt), 32'd0);
    chk("clr overflow", 32'(bus.overflow), 32'd0);
    chk("clr count", 32'(bus.count), 32'd8);
    drain("sat drain", 8);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
